// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_RX_PARITY_EN to add the even-parity bit and parity_err reporting.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_sync1, r_rxs;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [3:0]             r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]   r_data, w_data_nxt;
  logic                   r_armed, w_armed_nxt;
  logic                   r_dv, w_dv_nxt;
  logic                   r_fe, w_fe_nxt;
  logic                   w_tick;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par_nxt;
  logic                   r_pe, w_pe_nxt;
  logic                   w_perr;

  assign w_perr     = ^{r_shift, r_par};
  assign parity_err = r_pe;
`else
  assign parity_err = 1'b0;
`endif

  assign w_tick     = (r_cnt == CNT_FULL);
  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_armed <= 1'b0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_pe    <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_armed <= w_armed_nxt;
      r_dv    <= w_dv_nxt;
      r_fe    <= w_fe_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_pe    <= w_pe_nxt;
`endif
    end
  end

  // Every sample point lands where the bit timer wraps, H or N cycles after the previous one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_armed_nxt = r_armed;
    w_dv_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_pe_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (r_rxs) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rxs, r_shift[DATA_BITS-1:1]};
          if (r_bit == LAST_DATA) begin
            w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PAR;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_rxs;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_rxs) begin
            // Disarm so a held-low line (break) cannot be mistaken for a new start bit.
            w_fe_nxt    = 1'b1;
            w_armed_nxt = 1'b0;
            w_state_nxt = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            w_pe_nxt    = w_perr;
`endif
          end else if (r_bit == LAST_STOP) begin
            w_bit_nxt   = '0;
            w_armed_nxt = 1'b1;
            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (w_perr) begin
              w_pe_nxt = 1'b1;
            end else begin
              w_dv_nxt   = 1'b1;
              w_data_nxt = r_shift;
            end
`else
            w_dv_nxt   = 1'b1;
            w_data_nxt = r_shift;
`endif
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (r_rxs) begin
          w_armed_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver for the UART link. It deserializes frames arriving on rx: one start bit (0), DATA_BITS data bits sent LSB first, an optional even-parity bit, and STOP_BITS stop bits (1), with the line idling at 1. Each received byte is presented on a parallel output with a one-cycle valid strobe. This block is the receive-side counterpart to the frame generator used in the UART testbench and sits behind the pad/interface signal rx.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; must be an even number, minimum 4
DATA_BITS, 8, data bits per frame, 5..9
STOP_BITS, 2, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous reset, active-low
rx  input  1  serial input, asynchronous to clk
data_out  output  DATA_BITS  last good received word; held until the next good frame
data_valid  output  1  one-cycle pulse when data_out is updated
frame_err  output  1  one-cycle pulse when a stop bit is sampled as 0
parity_err  output  1  one-cycle pulse on a parity mismatch (see Optional Feature)
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0.
  - State goes to IDLE, all counters are cleared, the synchronizer flops are set to 1, and armed=0.
- rx passes through a 2-flop synchronizer; rxs is the synchronized value. All references to rx below mean rxs.
- armed: set when rxs=1 is sampled in IDLE. A start bit is accepted only while armed=1. This prevents locking onto the middle of a frame after reset or after a break.
- Let N=CLKS_PER_BIT and H=N/2. Cycle t0 is the first cycle in IDLE with armed=1 and rxs=0.
- State machine: IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE, plus WAIT_HIGH.
  - IDLE: on the t0 condition, go to START and clear the bit-timer.
  - START: resample rxs at t0+H.
    - If rxs=0, go to DATA.
    - If rxs=1 (glitch or false start), go back to IDLE with no flags raised.
  - DATA: bit i (0..DATA_BITS-1) is sampled at t0+H+(i+1)*N and shifted in LSB first. After the last bit, go to PAR if the parity feature is compiled in, otherwise go to STOP.
  - PAR: sampled at t0+H+(DATA_BITS+1)*N.
  - STOP: stop bit j is sampled at t0+H+(DATA_BITS+1+P+j)*N, where P is 1 with parity and 0 without.
    - If any stop bit samples 0: raise frame_err in the next cycle, set armed=0, go to WAIT_HIGH, and leave data_out unchanged.
    - If every stop bit samples 1 (and parity is good, or not compiled in): in the cycle after the last stop sample, load data_out, pulse data_valid, and go to IDLE with armed=1.
  - WAIT_HIGH: stay here until rxs=1, then go to IDLE with armed=1. This absorbs break conditions.
- Back-to-back frames: a new start edge may arrive immediately after the last stop bit and must be captured. IDLE is re-entered at the middle of the last stop bit, so no gap is required.
- data_valid and frame_err are never high in the same cycle. parity_err and frame_err may both pulse in the same cycle.
- Reset asserted mid-frame aborts the frame immediately; no partial data and no flags are produced.
- Latency from rx falling edge at the input pin to data_valid = 2 (synchronizer) + H + (DATA_BITS+1+P+STOP_BITS-1)*N + 1 cycles.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - The frame carries one even-parity bit after the data bits. Even parity means the XOR of the data bits and the parity bit is 0.
  - On a mismatch, parity_err pulses in the cycle after the last stop sample, data_valid stays low, and data_out is unchanged.
  - Stop-bit checking still runs; a frame can raise both errors.
- Not defined:
  - There is no PAR state.
  - parity_err is tied to 0.
  - Frame length is 1+DATA_BITS+STOP_BITS bits.

Test Plan:
- Defaults (no parity): send 0xA5 with 2 stop bits -> data_out=0xA5; data_valid high for exactly one cycle, 2+8+(8+1+1)*16+1=171 cycles after the rx falling edge; frame_err=0.
- Two back-to-back frames, 0x55 then 0xAA, with no idle gap -> two data_valid pulses 11*16=176 cycles apart; data_out shows 0x55, then 0xAA.
- rx low for only 5 cycles, then high -> no data_valid and no frame_err; busy returns to 0 by cycle 2+8+1; a following frame 0x3C is received correctly.
- Frame 0x0F with the first stop bit driven 0, rx then held low for 300 cycles -> frame_err pulses once; data_out keeps its previous value; busy stays 1 until rx goes high; the next frame 0x81 is received correctly.
- rst_n pulsed low in the middle of data bit 4 while rx keeps streaming the rest of the frame -> all outputs 0, no data_valid for that frame; the next full frame 0xC3 is received correctly.
- With UART_RX_PARITY_EN defined: 0x07 with parity bit 1 -> data_valid and data_out=0x07; the same byte with parity bit 0 -> parity_err pulses, no data_valid, data_out stays 0x07.
